// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : multiword_add_seq (with carry_skip_16bit)
//  Purpose  : WORDS x 16-bit add/subtract, one 16-bit carry-skip slice per
//             clock, LSB slice first, with a valid/ready handshake each side.
//  Revision : 1.0  initial release
// ============================================================================

module carry_skip_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic        w_c;
    logic        w_bc;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Four 4-bit ripple groups; a fully propagating group forwards its own
    // carry-in directly instead of waiting for the ripple.
    always_comb begin
        sum  = '0;
        w_c  = cin;
        w_bc = cin;
        for (int blk = 0; blk < 4; blk++) begin
            w_bc = w_c;
            for (int bit_i = 0; bit_i < 4; bit_i++) begin
                sum[blk*4 + bit_i] = w_p[blk*4 + bit_i] ^ w_c;
                w_c = w_g[blk*4 + bit_i] | (w_p[blk*4 + bit_i] & w_c);
            end
            if (&w_p[blk*4 +: 4]) begin
                w_c = w_bc;
            end
        end
        cout = w_c;
    end
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  overflow
);
    localparam int N  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] C_LAST_IDX = IW'(WORDS - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [IW+3:0] w_base;
    logic [15:0]   w_sa;
    logic [15:0]   w_sb;
    logic [15:0]   w_ssum;
    logic          w_scout;
    logic          w_last;

    assign w_base = {r_idx, 4'b0000};
    assign w_sa   = r_a[w_base +: 16];
    assign w_sb   = r_b[w_base +: 16];
    assign w_last = (r_idx == C_LAST_IDX);

    carry_skip_16bit u_adder (
        .a    (w_sa),
        .b    (w_sb),
        .cin  (r_carry),
        .sum  (w_ssum),
        .cout (w_scout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= op_a;
                        r_b        <= sub ? ~op_b : op_b;
                        r_carry    <= sub ? ~cin : cin;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 16] <= w_ssum;
                    r_carry             <= w_scout;
                    if (w_last) begin
                        r_cout      <= w_scout;
                        // Sign of the top slice decides signed overflow.
                        r_ovf       <= (r_a[N-1] == r_b[N-1]) && (w_ssum[15] != r_a[N-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
endmodule

`default_nettype wire
